// File: rtl/alu_issue.sv
// alu_issue: issue stage in front of the ALU.
// Decodes MIPS R-type and ALU I-type instructions, reads rs/rt from the register
// file in the same cycle and presents one registered ALU op per accepted
// instruction under a valid/ready handshake. rd_addr travels with each op.
// Only XLEN = 32 is supported.
// Optional feature: define ALU_ISSUE_STATS_EN to add saturating issued/illegal
// counters (issued_cnt, illegal_cnt, CNT_W bits wide).
module alu_issue #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic [4:0]        rs_addr,
    output logic [4:0]        rt_addr,
    input  logic [XLEN-1:0]   rs_data,
    input  logic [XLEN-1:0]   rt_data,
    output logic [XLEN-1:0]   operand_a,
    output logic [XLEN-1:0]   operand_b,
    output logic [5:0]        func,
    output logic [4:0]        rd_addr,
    output logic              alu_valid,
    input  logic              alu_ready,
    output logic              illegal
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [CNT_W-1:0]  issued_cnt,
    output logic [CNT_W-1:0]  illegal_cnt
`endif
);

    // Primary opcodes
    localparam logic [5:0] OpSpecial = 6'd0;
    localparam logic [5:0] OpAddi    = 6'd8;
    localparam logic [5:0] OpAddiu   = 6'd9;
    localparam logic [5:0] OpAndi    = 6'd12;
    localparam logic [5:0] OpOri     = 6'd13;
    localparam logic [5:0] OpXori    = 6'd14;

    // R-type funct codes
    localparam logic [5:0] FnSll  = 6'd0;
    localparam logic [5:0] FnSrl  = 6'd2;
    localparam logic [5:0] FnSra  = 6'd3;
    localparam logic [5:0] FnSllv = 6'd4;
    localparam logic [5:0] FnSrlv = 6'd6;
    localparam logic [5:0] FnSrav = 6'd7;
    localparam logic [5:0] FnAdd  = 6'd32;
    localparam logic [5:0] FnAddu = 6'd33;
    localparam logic [5:0] FnSub  = 6'd34;
    localparam logic [5:0] FnSubu = 6'd35;
    localparam logic [5:0] FnAnd  = 6'd36;
    localparam logic [5:0] FnOr   = 6'd37;
    localparam logic [5:0] FnXor  = 6'd38;
    localparam logic [5:0] FnNor  = 6'd39;

    // ALU function codes that differ from the instruction's own funct
    localparam logic [5:0] AluAdd  = 6'd32;
    localparam logic [5:0] AluSub  = 6'd34;
    localparam logic [5:0] AluAnd  = 6'd36;
    localparam logic [5:0] AluOr   = 6'd37;
    localparam logic [5:0] AluXor  = 6'd38;
    localparam logic [5:0] AluNor  = 6'd43;
    localparam logic [5:0] AluAddi = 6'd8;

    // Instruction fields
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [4:0]  rd_field;
    logic [15:0] imm;

    assign opcode   = instr[31:26];
    assign funct    = instr[5:0];
    assign shamt    = instr[10:6];
    assign rd_field = instr[15:11];
    assign imm      = instr[15:0];

    assign rs_addr = instr[25:21];
    assign rt_addr = instr[20:16];

    logic [XLEN-1:0] imm_sext;
    logic [XLEN-1:0] imm_zext;
    logic [XLEN-1:0] shamt_ext;
    logic [XLEN-1:0] rs_shamt_ext;

    assign imm_sext     = {{(XLEN-16){imm[15]}}, imm};
    assign imm_zext     = {{(XLEN-16){1'b0}}, imm};
    assign shamt_ext    = {{(XLEN-5){1'b0}}, shamt};
    assign rs_shamt_ext = {{(XLEN-5){1'b0}}, rs_data[4:0]};

    // Decoded next-op values
    logic            dec_legal;
    logic [5:0]      dec_func;
    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;
    logic [4:0]      dec_rd;

    // Output register state
    logic            valid_q;
    logic            illegal_q;
    logic [XLEN-1:0] operand_a_q;
    logic [XLEN-1:0] operand_b_q;
    logic [5:0]      func_q;
    logic [4:0]      rd_addr_q;

    logic accept;

    // The slot can take a new op when empty or when the current op drains this edge
    assign instr_ready = clk_en && (!valid_q || alu_ready);
    assign accept      = instr_valid && instr_ready;

    // Decode the instruction into ALU function, operands and destination
    always_comb begin
        dec_legal = 1'b1;
        dec_func  = funct;
        dec_a     = rs_data;
        dec_b     = rt_data;
        dec_rd    = rd_field;
        if (opcode == OpSpecial) begin
            case (funct)
                FnSll, FnSrl, FnSra: begin
                    dec_a = shamt_ext;
                end
                FnSllv, FnSrlv, FnSrav: begin
                    dec_a = rs_shamt_ext;
                end
                FnAdd, FnAddu: dec_func = AluAdd;
                FnSub, FnSubu: dec_func = AluSub;
                FnAnd, FnOr, FnXor: dec_func = funct;
                FnNor: dec_func = AluNor;
                default: dec_legal = 1'b0;
            endcase
        end else begin
            // I-type: destination is rt, operand_b carries the immediate
            dec_rd = rt_addr;
            case (opcode)
                OpAddi: begin
                    dec_func = AluAddi;
                    dec_b    = imm_sext;
                end
                OpAddiu: begin
                    dec_func = AluAdd;
                    dec_b    = imm_sext;
                end
                OpAndi: begin
                    dec_func = AluAnd;
                    dec_b    = imm_zext;
                end
                OpOri: begin
                    dec_func = AluOr;
                    dec_b    = imm_zext;
                end
                OpXori: begin
                    dec_func = AluXor;
                    dec_b    = imm_zext;
                end
                default: dec_legal = 1'b0;
            endcase
        end
    end

    // Output slot: load on accept, drain on alu_ready, hold everything while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            illegal_q   <= 1'b0;
            operand_a_q <= '0;
            operand_b_q <= '0;
            func_q      <= '0;
            rd_addr_q   <= '0;
        end else if (clk_en) begin
            if (accept) begin
                if (dec_legal) begin
                    valid_q     <= 1'b1;
                    illegal_q   <= 1'b0;
                    operand_a_q <= dec_a;
                    operand_b_q <= dec_b;
                    func_q      <= dec_func;
                    rd_addr_q   <= dec_rd;
                end else begin
                    // Illegal op is consumed as a bubble; operand registers keep old values
                    valid_q   <= 1'b0;
                    illegal_q <= 1'b1;
                end
            end else begin
                illegal_q <= 1'b0;
                if (alu_ready) begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign alu_valid = valid_q;
    assign illegal   = illegal_q;
    assign operand_a = operand_a_q;
    assign operand_b = operand_b_q;
    assign func      = func_q;
    assign rd_addr   = rd_addr_q;

`ifdef ALU_ISSUE_STATS_EN
    logic [CNT_W-1:0] issued_cnt_q;
    logic [CNT_W-1:0] illegal_cnt_q;

    // Saturating statistics counters for consumed instructions
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_cnt_q  <= '0;
            illegal_cnt_q <= '0;
        end else if (clk_en && accept) begin
            if (dec_legal) begin
                if (issued_cnt_q != '1) begin
                    issued_cnt_q <= issued_cnt_q + CNT_W'(1);
                end
            end else begin
                if (illegal_cnt_q != '1) begin
                    illegal_cnt_q <= illegal_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign issued_cnt  = issued_cnt_q;
    assign illegal_cnt = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios plus randomized traffic
// checked against a behavioural model of the issue slot.
module tb_alu_issue;

    logic        clk;
    logic        rst;
    logic        clk_en;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [5:0]  func;
    logic [4:0]  rd_addr;
    logic        alu_valid;
    logic        alu_ready;
    logic        illegal;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] issued_cnt;
    logic [15:0] illegal_cnt;
`endif

    logic [31:0] rf [32];

    int n_checks = 0;
    int n_fail   = 0;

    assign rs_data = rf[rs_addr];
    assign rt_data = rf[rt_addr];

    alu_issue #(.XLEN(32), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_en      (clk_en),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .func        (func),
        .rd_addr     (rd_addr),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .illegal     (illegal)
`ifdef ALU_ISSUE_STATS_EN
        ,
        .issued_cnt  (issued_cnt),
        .illegal_cnt (illegal_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        legal;
        logic [5:0]  func;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } op_t;

    // Reference model state
    logic m_valid;
    logic m_illegal;
    op_t  m_op;
    int   m_iss;
    int   m_ill;

    // Mnemonic-level meaning of an instruction word
    function automatic op_t ref_decode(input logic [31:0] iw);
        op_t o;
        int  op  = int'(iw[31:26]);
        int  fn  = int'(iw[5:0]);
        int  rs  = int'(iw[25:21]);
        int  rt  = int'(iw[20:16]);
        int  imm = int'(iw[15:0]);
        o.legal = 1'b1;
        o.a     = rf[rs];
        o.b     = rf[rt];
        o.func  = 6'(fn);
        o.rd    = 5'(rt);
        if (op == 0) begin
            o.rd = iw[15:11];
            if (fn == 0 || fn == 2 || fn == 3) o.a = 32'(iw[10:6]);
            else if (fn == 4 || fn == 6 || fn == 7) o.a = rf[rs] % 32;
            else if (fn == 32 || fn == 33) o.func = 6'd32;
            else if (fn == 34 || fn == 35) o.func = 6'd34;
            else if (fn >= 36 && fn <= 38) o.func = 6'(fn);
            else if (fn == 39) o.func = 6'd43;
            else o.legal = 1'b0;
        end else begin
            if (op == 8 || op == 9) begin
                o.func = (op == 8) ? 6'd8 : 6'd32;
                o.b    = (imm >= 32768) ? 32'(imm - 65536) : 32'(imm);
            end else if (op == 12 || op == 13 || op == 14) begin
                o.func = (op == 12) ? 6'd36 : (op == 13) ? 6'd37 : 6'd38;
                o.b    = 32'(imm);
            end else begin
                o.legal = 1'b0;
            end
        end
        return o;
    endfunction

    // Advance the model by one clock edge using the currently driven inputs
    task automatic model_step();
        op_t d;
        if (rst) begin
            m_valid   = 1'b0;
            m_illegal = 1'b0;
            m_op      = '0;
            m_iss     = 0;
            m_ill     = 0;
        end else if (clk_en) begin
            if (instr_valid && (!m_valid || alu_ready)) begin
                d = ref_decode(instr);
                if (d.legal) begin
                    m_valid   = 1'b1;
                    m_illegal = 1'b0;
                    m_op      = d;
                    if (m_iss < 65535) m_iss++;
                end else begin
                    m_valid   = 1'b0;
                    m_illegal = 1'b1;
                    if (m_ill < 65535) m_ill++;
                end
            end else begin
                m_illegal = 1'b0;
                if (alu_ready) m_valid = 1'b0;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        instr_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        // Park an op in the slot under backpressure, then reset while instr_valid is high
        rst = 1'b0; clk_en = 1'b1; alu_ready = 1'b0;
        rf[4] = 32'd11; rf[5] = 32'd22;
        instr = 32'h00851020; instr_valid = 1'b1;
        tick();
        n_checks++; if (alu_valid !== 1'b1) begin n_fail++; $display("FAIL reset_preload_valid: got %0b want 1", alu_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0; instr_valid = 1'b0;
        n_checks++; if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", alu_valid); end
        n_checks++; if (func !== 6'd0) begin n_fail++; $display("FAIL reset_func: got %0d want 0", func); end
        n_checks++; if (operand_a !== 32'd0) begin n_fail++; $display("FAIL reset_a: got %h want 0", operand_a); end
        n_checks++; if (operand_b !== 32'd0) begin n_fail++; $display("FAIL reset_b: got %h want 0", operand_b); end
        n_checks++; if (rd_addr !== 5'd0) begin n_fail++; $display("FAIL reset_rd: got %0d want 0", rd_addr); end
        n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %0b want 0", illegal); end
    endtask

    task automatic test_rtype_add();
        do_reset();
        rf[4] = 32'd5; rf[5] = 32'd7; alu_ready = 1'b1;
        instr = 32'h00851020; instr_valid = 1'b1;
        #1;
        n_checks++; if (rs_addr !== 5'd4 || rt_addr !== 5'd5) begin n_fail++; $display("FAIL add_addr: got rs=%0d rt=%0d want rs=4 rt=5", rs_addr, rt_addr); end
        n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready: got %0b want 1", instr_ready); end
        tick();
        instr_valid = 1'b0;
        n_checks++; if (alu_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %0b want 1", alu_valid); end
        n_checks++; if (func !== 6'd32) begin n_fail++; $display("FAIL add_func: got %0d want 32", func); end
        n_checks++; if (operand_a !== 32'd5 || operand_b !== 32'd7) begin n_fail++; $display("FAIL add_ops: got a=%h b=%h want a=5 b=7", operand_a, operand_b); end
        n_checks++; if (rd_addr !== 5'd2) begin n_fail++; $display("FAIL add_rd: got %0d want 2", rd_addr); end
        tick();
        n_checks++; if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain: got %0b want 0", alu_valid); end
    endtask

    task automatic test_itype();
        do_reset();
        rf[4] = 32'd3; alu_ready = 1'b1;
        instr = 32'h2082FFFF; instr_valid = 1'b1;
        tick();
        n_checks++; if (func !== 6'd8 || operand_b !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL addi: got func=%0d b=%h want func=8 b=ffffffff", func, operand_b); end
        n_checks++; if (operand_a !== 32'd3 || rd_addr !== 5'd2) begin n_fail++; $display("FAIL addi_a_rd: got a=%h rd=%0d want a=3 rd=2", operand_a, rd_addr); end
        instr = 32'h3482FFFF;
        tick();
        instr_valid = 1'b0;
        n_checks++; if (func !== 6'd37 || operand_b !== 32'h0000FFFF || rd_addr !== 5'd2) begin n_fail++; $display("FAIL ori: got func=%0d b=%h rd=%0d want func=37 b=0000ffff rd=2", func, operand_b, rd_addr); end
        n_checks++; if (alu_valid !== 1'b1) begin n_fail++; $display("FAIL ori_valid: got %0b want 1", alu_valid); end
    endtask

    task automatic test_shift();
        do_reset();
        rf[4] = 32'h80000000; rf[3] = 32'h00000123; alu_ready = 1'b1;
        instr = 32'h00041103; instr_valid = 1'b1;
        tick();
        n_checks++; if (func !== 6'd3 || operand_a !== 32'd4 || operand_b !== 32'h80000000) begin n_fail++; $display("FAIL sra: got func=%0d a=%h b=%h want func=3 a=4 b=80000000", func, operand_a, operand_b); end
        instr = {6'd0, 5'd3, 5'd4, 5'd2, 5'd0, 6'd7};
        tick();
        n_checks++; if (func !== 6'd7 || operand_a !== 32'd3) begin n_fail++; $display("FAIL srav: got func=%0d a=%h want func=7 a=3", func, operand_a); end
        rf[0] = 32'd0;
        instr = 32'h00000000;
        tick();
        instr_valid = 1'b0;
        n_checks++; if (alu_valid !== 1'b1 || func !== 6'd0 || operand_a !== 32'd0 || rd_addr !== 5'd0) begin n_fail++; $display("FAIL nop: got v=%0b func=%0d a=%h rd=%0d want v=1 func=0 a=0 rd=0", alu_valid, func, operand_a, rd_addr); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 32; i++) rf[i] = 32'h100 + 32'(i);
        alu_ready = 1'b0;
        instr = 32'h00851020; instr_valid = 1'b1;
        tick();
        instr = {6'd0, 5'd6, 5'd7, 5'd3, 5'd0, 6'd34};
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %0b want 0", i, instr_ready); end
            tick();
            n_checks++; if (alu_valid !== 1'b1 || func !== 6'd32 || operand_a !== 32'h104 || operand_b !== 32'h105 || rd_addr !== 5'd2) begin n_fail++; $display("FAIL bp_hold[%0d]: got v=%0b func=%0d a=%h b=%h rd=%0d", i, alu_valid, func, operand_a, operand_b, rd_addr); end
        end
        alu_ready = 1'b1;
        #1;
        n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %0b want 1", instr_ready); end
        tick();
        n_checks++; if (alu_valid !== 1'b1 || func !== 6'd34 || operand_a !== 32'h106 || operand_b !== 32'h107 || rd_addr !== 5'd3) begin n_fail++; $display("FAIL bp_next: got v=%0b func=%0d a=%h b=%h rd=%0d", alu_valid, func, operand_a, operand_b, rd_addr); end
        for (int i = 0; i < 4; i++) begin
            instr = {6'd0, 5'(i + 8), 5'(i + 12), 5'(i + 16), 5'd0, 6'(36 + i)};
            tick();
            n_checks++; if (alu_valid !== 1'b1 || func !== m_op.func || operand_a !== m_op.a || rd_addr !== m_op.rd) begin n_fail++; $display("FAIL b2b[%0d]: got v=%0b func=%0d a=%h rd=%0d want v=1 func=%0d a=%h rd=%0d", i, alu_valid, func, operand_a, rd_addr, m_op.func, m_op.a, m_op.rd); end
        end
        instr_valid = 1'b0;
        tick();
        n_checks++; if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %0b want 0", alu_valid); end
    endtask

    task automatic test_illegal();
        do_reset();
        alu_ready = 1'b1;
        instr = 32'h00851020; instr_valid = 1'b1;
        tick();
        instr = 32'h8C820000;
        tick();
        instr_valid = 1'b0;
        n_checks++; if (illegal !== 1'b1 || alu_valid !== 1'b0) begin n_fail++; $display("FAIL illegal_pulse: got ill=%0b v=%0b want ill=1 v=0", illegal, alu_valid); end
`ifdef ALU_ISSUE_STATS_EN
        n_checks++; if (illegal_cnt !== 16'd1 || issued_cnt !== 16'd1) begin n_fail++; $display("FAIL illegal_cnt: got ill=%0d iss=%0d want ill=1 iss=1", illegal_cnt, issued_cnt); end
`endif
        tick();
        n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_clear: got %0b want 0", illegal); end
        // Stall: held pulse and no acceptance while clk_en is low
        instr = 32'h8C820000; instr_valid = 1'b1;
        tick();
        clk_en = 1'b0; instr = 32'h00851020;
        #1;
        n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready: got %0b want 0", instr_ready); end
        tick(); tick();
        n_checks++; if (illegal !== 1'b1 || alu_valid !== 1'b0) begin n_fail++; $display("FAIL stall_hold: got ill=%0b v=%0b want ill=1 v=0", illegal, alu_valid); end
        clk_en = 1'b1;
        tick();
        instr_valid = 1'b0;
        n_checks++; if (illegal !== 1'b0 || alu_valid !== 1'b1 || func !== 6'd32) begin n_fail++; $display("FAIL stall_resume: got ill=%0b v=%0b func=%0d want ill=0 v=1 func=32", illegal, alu_valid, func); end
    endtask

`ifdef ALU_ISSUE_STATS_EN
    task automatic test_saturation();
        do_reset();
        alu_ready = 1'b1;
        instr = 32'hFC000000; instr_valid = 1'b1;
        for (int i = 0; i < 65537; i++) tick();
        instr_valid = 1'b0;
        n_checks++; if (illegal_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_illegal_cnt: got %h want ffff", illegal_cnt); end
        n_checks++; if (issued_cnt !== 16'd0) begin n_fail++; $display("FAIL sat_issued_cnt: got %h want 0", issued_cnt); end
    endtask
`endif

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [31:0] pick;
        logic [5:0]  fn_list [14];
        logic [5:0]  op_list [5];
        fn_list = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd32, 6'd33,
                    6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39};
        op_list = '{6'd8, 6'd9, 6'd12, 6'd13, 6'd14};
        r    = $urandom;
        pick = $urandom_range(0, 9);
        if (pick < 2) return r;
        if (pick < 6) return {6'd0, r[25:6], fn_list[$urandom_range(0, 13)]};
        return {op_list[$urandom_range(0, 4)], r[25:0]};
    endfunction

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        for (int n = 0; n < 600; n++) begin
            rst         = ($urandom_range(0, 99) == 0);
            clk_en      = ($urandom_range(0, 9) != 0);
            instr_valid = ($urandom_range(0, 3) != 0);
            alu_ready   = ($urandom_range(0, 2) != 0);
            instr       = rand_instr();
            #1;
            n_checks++; if (instr_ready !== (clk_en && (!m_valid || alu_ready))) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %0b want %0b", n, instr_ready, clk_en && (!m_valid || alu_ready)); end
            tick();
            n_checks++; if (alu_valid !== m_valid || illegal !== m_illegal) begin n_fail++; $display("FAIL rnd_flags[%0d]: got v=%0b ill=%0b want v=%0b ill=%0b", n, alu_valid, illegal, m_valid, m_illegal); end
            if (m_valid) begin
                n_checks++; if (func !== m_op.func || operand_a !== m_op.a || operand_b !== m_op.b || rd_addr !== m_op.rd) begin n_fail++; $display("FAIL rnd_op[%0d]: got func=%0d a=%h b=%h rd=%0d want func=%0d a=%h b=%h rd=%0d", n, func, operand_a, operand_b, rd_addr, m_op.func, m_op.a, m_op.b, m_op.rd); end
            end
`ifdef ALU_ISSUE_STATS_EN
            n_checks++; if (int'(issued_cnt) != m_iss || int'(illegal_cnt) != m_ill) begin n_fail++; $display("FAIL rnd_cnt[%0d]: got iss=%0d ill=%0d want iss=%0d ill=%0d", n, issued_cnt, illegal_cnt, m_iss, m_ill); end
`endif
        end
        rst = 1'b0; clk_en = 1'b1; instr_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        rst = 1'b1; clk_en = 1'b1; instr_valid = 1'b0; alu_ready = 1'b1; instr = 32'd0;
        m_valid = 1'b0; m_illegal = 1'b0; m_op = '0; m_iss = 0; m_ill = 0;
        #1;
        tick();
        rst = 1'b0;
        test_reset();
        test_rtype_add();
        test_itype();
        test_shift();
        test_back_to_back();
        test_illegal();
        test_random();
`ifdef ALU_ISSUE_STATS_EN
        test_saturation();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Issue stage that drives the ALU's operand_a / operand_b / func interface.
- Decodes MIPS R-type and ALU I-type instructions and reads rs/rt from the register file.
- Selects shift amount or immediate, then presents one registered ALU operation per accepted instruction under a valid/ready handshake.
- Sits between instruction fetch/decode and the ALU; rd_addr travels alongside each op for writeback.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- CNT_W, 16, width of the statistics counters (used only with the optional feature).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- clk_en  input  1  global stall. When low, all state holds and instr_ready=0.
- instr_valid  input  1  instr is valid.
- instr_ready  output  1  combinational: clk_en && (!alu_valid || alu_ready).
- instr  input  32  MIPS instruction word.
- rs_addr  output  5  combinational: instr[25:21].
- rt_addr  output  5  combinational: instr[20:16].
- rs_data  input  32  register file read data for rs_addr, same cycle.
- rt_data  input  32  register file read data for rt_addr, same cycle.
- operand_a  output  32  registered ALU operand a.
- operand_b  output  32  registered ALU operand b.
- func  output  6  registered ALU function code.
- rd_addr  output  5  registered writeback destination.
- alu_valid  output  1  registered; operation on operand_a/b/func is valid.
- alu_ready  input  1  downstream accepts the op.
- illegal  output  1  registered one-cycle pulse: an unsupported instruction was consumed.
- issued_cnt  output  CNT_W  only with ALU_ISSUE_STATS_EN.
- illegal_cnt  output  CNT_W  only with ALU_ISSUE_STATS_EN.

Behaviour:
- Reset: alu_valid=0, illegal=0, operand_a=0, operand_b=0, func=0, rd_addr=0, counters=0.
  - Reset wins over every other event.
  - An op held mid-handshake is dropped.
- Accept condition: instr_valid && instr_ready. Latency is 1 cycle: alu_valid rises on the edge after accept.
- Output register behaviour:
  - While alu_valid && !alu_ready, operand_a, operand_b, func and rd_addr hold stable.
  - Output clears (alu_valid=0) when alu_ready=1 and no new accept occurs.
  - Simultaneous drain and accept: the new op replaces the old one in the same edge, giving back-to-back throughput of 1 op/cycle.
- R-type decode (opcode instr[31:26]=0; funct=instr[5:0]; rd=instr[15:11]):
  - funct 0/2/3 (sll/srl/sra): func=funct, operand_a={27'b0, shamt instr[10:6]}, operand_b=rt_data.
  - funct 4/6/7 (sllv/srlv/srav): func=funct, operand_a={27'b0, rs_data[4:0]}, operand_b=rt_data.
  - funct 32/33 (add/addu): func=32.
  - funct 34/35 (sub/subu): func=34.
  - funct 36/37/38: func=funct.
  - funct 39 (nor): func=43.
  - For all R-type except shifts: operand_a=rs_data, operand_b=rt_data.
  - Writeback destination: rd_addr=rd.
- I-type decode (imm=instr[15:0]; rd_addr=rt; operand_a=rs_data):
  - op 8 addi: func=8, operand_b=sign-extended imm.
  - op 9 addiu: func=32, operand_b=sign-extended imm.
  - op 12 andi: func=36, operand_b=zero-extended imm.
  - op 13 ori: func=37, operand_b=zero-extended imm.
  - op 14 xori: func=38, operand_b=zero-extended imm.
- Illegal instructions (any other opcode or funct):
  - Instruction is consumed.
  - On the accept edge, illegal=1 and alu_valid is cleared (the illegal instruction occupies the slot as a bubble).
  - illegal=0 on the next edge unless another illegal instruction is accepted.
- All-zero instr (nop) decodes as sll r0 and issues normally.
- clk_en=0: no register changes, including the illegal pulse, which is held; instr_ready=0.

Optional Feature:
- Macro ALU_ISSUE_STATS_EN.
- Defined:
  - issued_cnt increments on each accepted legal instruction.
  - illegal_cnt increments on each accepted illegal instruction.
  - Both counters saturate at all-ones (no wrap) and clear on rst.
- Undefined: counter ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset mid-stall: alu_valid=1, alu_ready=0, assert rst 1 cycle -> next cycle alu_valid=0, func=0, operand_a=0, illegal=0.
- instr=0x00851020 (add $2,$4,$5), rs_data=5, rt_data=7, alu_ready=1 -> one cycle later alu_valid=1, func=32, operand_a=5, operand_b=7, rd_addr=2.
- instr=0x2082FFFF (addi $2,$4,-1), rs_data=3 -> func=8, operand_b=0xFFFFFFFF.
  - Then ori 0x3482FFFF -> func=37, operand_b=0x0000FFFF, rd_addr=2.
- Shifts:
  - sra 0x00041103 ($2=$4>>>4), rt_data=0x80000000 -> func=3, operand_a=4.
  - srav with rs_data=0x00000123 -> operand_a=3.
- Backpressure: hold alu_ready=0 for 3 cycles with instr_valid=1 -> instr_ready=0, outputs stable. Release -> next op issued the following edge; 4 back-to-back ops with alu_ready=1 give alu_valid high 4 consecutive cycles.
- Illegal 0x8C820000 (lw) -> illegal=1 for exactly one cycle, alu_valid=0.
  - With ALU_ISSUE_STATS_EN: illegal_cnt=1, issued_cnt unchanged.
  - Preload near saturation: counter stays at 0xFFFF.
